cache_bus_arbiter: RTL
======================

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data-port wins allowed while inst_req is pending.
REQ-002 Parameter DATA_FIRST, default 1: 1 = data port has priority over inst port; 0 = inst port has priority.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 inst_req / data_req  in  1 each  request from the I-cache / D-cache.
REQ-006 inst_wr / data_wr  in  1 each  1 = write.
REQ-007 inst_size / data_size  in  2 each  00 byte, 01 half, 10 word.
REQ-008 inst_addr / data_addr  in  32 each  byte address.
REQ-009 inst_wdata / data_wdata  in  32 each  write data.
REQ-010 inst_rdata / data_rdata  out  32 each  read data, valid only with the matching data_ok.
REQ-011 inst_addr_ok / data_addr_ok  out  1 each  request accepted.
REQ-012 inst_data_ok / data_data_ok  out  1 each  transaction complete.
REQ-013 mem_req  out  1  request to the AXI bridge.
REQ-014 mem_wr, mem_size, mem_addr, mem_wdata  out  1/2/32/32  fields of the granted requester.
REQ-015 mem_rdata  in  32  read data.
REQ-016 mem_addr_ok, mem_data_ok  in  1 each  bridge handshakes.

Function
REQ-017 FSM states are IDLE, ADDR and DATA; at most one transaction is outstanding.
REQ-018 In IDLE with any req high, the winner is registered into owner (0 = inst, 1 = data) and the next state is ADDR; with no request the FSM stays in IDLE.
REQ-019 Winner rules:
  - Only one requester high: that requester wins.
  - Both high: the DATA_FIRST priority side wins, unless starve_cnt == STARVE_LIMIT, in which case the other side wins.
REQ-020 starve_cnt counts +1 on each IDLE arbitration in which both requesters are high and the non-priority side loses; it clears to 0 when the non-priority side wins or when only one requester is high; it saturates at STARVE_LIMIT.
REQ-021 In ADDR, mem_req = 1 and the mem_* fields are muxed from owner; the requester holds its fields stable until its addr_ok.
REQ-022 In ADDR, mem_addr_ok = 1 causes:
  - the owner's addr_ok to pulse in the same cycle (combinational pass-through);
  - a move to DATA, or to IDLE if mem_data_ok = 1 in the same cycle.
REQ-023 In DATA, mem_req = 0; mem_data_ok = 1 drives the owner's data_ok in the same cycle, with rdata = mem_rdata, and the FSM returns to IDLE.
REQ-024 The non-owner's addr_ok and data_ok are always 0; a mem_data_ok arriving in IDLE or ADDR without a prior address acceptance is ignored.
REQ-025 Minimum latency is req to addr_ok in 1 cycle and to data_ok in 1 cycle; a new arbitration follows the cycle after data_ok.
REQ-026 Both rdata outputs equal mem_rdata; consumers qualify it with data_ok.

Reset
REQ-027 On rst: state = IDLE, owner = 0, starve_cnt = 0, mem_req = 0, all addr_ok/data_ok outputs = 0.
REQ-028 rst in ADDR or DATA abandons the transaction with no data_ok pulse; the AXI bridge is reset by the same rst.
REQ-029 The first arbitration occurs on the first cycle after rst deasserts.

Structure
REQ-030 The shared package holds the state encoding (IDLE/ADDR/DATA), the owner encoding (OWN_INST/OWN_DATA) and the size codes.
REQ-031 Winner selection plus starve_cnt form one sub-module, arb_select; the FSM and muxing remain in cache_bus_arbiter.

Verification
REQ-032 data_req only, addr 0x0000_0100 read; bridge addr_ok at cycle 1, data_ok at cycle 3 with 0xDEADBEEF -> data_addr_ok @1, data_data_ok @3, data_rdata = 0xDEADBEEF, inst outputs stay 0.
REQ-033 inst_req and data_req high together, DATA_FIRST = 1 -> data granted first; inst granted on the next arbitration after data_data_ok.
REQ-034 data_req held continuously, inst_req pending, STARVE_LIMIT = 4 -> 4 data grants, then 1 inst grant, then starve_cnt = 0.
REQ-035 mem_addr_ok and mem_data_ok in the same cycle (write, size 01, addr 0x0000_0002) -> addr_ok and data_ok pulse together; FSM goes ADDR to IDLE; mem_wr = 1, mem_size = 01.
REQ-036 rst asserted while in DATA -> next cycle state = IDLE, no data_ok; a later mem_data_ok is ignored.
REQ-037 Bridge stalls addr_ok for 5 cycles -> mem_req held at 1 with mem_addr stable for all 5 cycles; owner unchanged.

Source files
------------

// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types for the I/D-cache to AXI-bridge arbiter.
// Holds the FSM state encoding, the owner encoding and the transfer size codes.
// Also holds a width helper for the starvation counter.
package cache_bus_arbiter_pkg;

  // Arbiter FSM: one outstanding transaction at a time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Which cache currently owns the memory bus.
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // Transfer size codes shared by both caches and the bridge.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  // Counter width able to hold 0..limit; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Bundle of the two cache request ports and the bridge port.
// The master modport is the arbiter's view; slave is the caches/bridge side.
// Requesters hold their fields stable until their addr_ok.
interface cache_bus_arbiter_if;
  import cache_bus_arbiter_pkg::*;

  // I-cache port
  logic        inst_req;
  logic        inst_wr;
  size_t       inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  // D-cache port
  logic        data_req;
  logic        data_wr;
  size_t       data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  // AXI bridge port
  logic        mem_req;
  logic        mem_wr;
  size_t       mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_addr_ok, mem_data_ok
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_addr_ok, mem_data_ok
  );

endinterface

// File: rtl/cache_bus_arbiter_arb_select.sv
// Winner selection between I-cache and D-cache with starvation protection.
// Combinational winner; starve counter updates only on an IDLE arbitration.
// After STARVE_LIMIT consecutive losses the non-priority side is forced through.
module cache_bus_arbiter_arb_select
  import cache_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter bit DATA_FIRST   = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   inst_req,
  input  logic   data_req,
  input  logic   arb_en,
  output owner_t winner
);

  localparam int     CNT_W = cnt_width(STARVE_LIMIT);
  localparam owner_t PRIO  = DATA_FIRST ? OWN_DATA : OWN_INST;
  localparam owner_t OTHER = DATA_FIRST ? OWN_INST : OWN_DATA;

  logic [CNT_W-1:0] starve_cnt;
  logic             both_req;
  logic             at_limit;

  assign both_req = inst_req && data_req;
  assign at_limit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Pick the winner: lone requester wins; on contention priority side wins unless starved out.
  always_comb begin
    winner = OWN_INST;
    if (both_req) begin
      winner = at_limit ? OTHER : PRIO;
    end else if (data_req) begin
      winner = OWN_DATA;
    end
  end

  // Count consecutive contended losses of the non-priority side; any other arbitration clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (both_req && !at_limit) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates I-cache and D-cache requests onto a single AXI-bridge port.
// Latency: arbitrate in IDLE, request in ADDR the next cycle; addr_ok/data_ok pass straight through.
// Backpressure: mem_req stays high with fields held until the bridge returns mem_addr_ok.
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter bit DATA_FIRST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_bus_arbiter_if.master   bus
);

  state_t state;
  owner_t owner;
  owner_t winner;
  logic   mem_req_q;
  logic   arb_en;
  logic   addr_hit;
  logic   data_hit;

  // Arbitration happens only from IDLE with at least one request pending.
  assign arb_en = (state == ST_IDLE) && (bus.inst_req || bus.data_req);

  cache_bus_arbiter_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .DATA_FIRST   (DATA_FIRST)
  ) arb_select (
    .clk      (clk),
    .rst      (rst),
    .inst_req (bus.inst_req),
    .data_req (bus.data_req),
    .arb_en   (arb_en),
    .winner   (winner)
  );

  // Transaction FSM with registered owner and mem_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_INST;
      mem_req_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_en) begin
            owner     <= winner;
            state     <= ST_ADDR;
            mem_req_q <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (bus.mem_addr_ok) begin
            mem_req_q <= 1'b0;
            // Bridge may finish the whole transfer in the accept cycle.
            state     <= bus.mem_data_ok ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.mem_data_ok) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Handshakes only count while a transaction is live; data_ok without a prior
  // address acceptance is dropped, and reset abandons whatever is in flight.
  assign addr_hit = !rst && (state == ST_ADDR) && bus.mem_addr_ok;
  assign data_hit = !rst && bus.mem_data_ok && ((state == ST_DATA) || addr_hit);

  // Bridge request fields follow the current owner.
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = (owner == OWN_DATA) ? bus.data_wr    : bus.inst_wr;
  assign bus.mem_size  = (owner == OWN_DATA) ? bus.data_size  : bus.inst_size;
  assign bus.mem_addr  = (owner == OWN_DATA) ? bus.data_addr  : bus.inst_addr;
  assign bus.mem_wdata = (owner == OWN_DATA) ? bus.data_wdata : bus.inst_wdata;

  // Acknowledge only the owner; the other side always sees zeros.
  assign bus.inst_addr_ok = addr_hit && (owner == OWN_INST);
  assign bus.data_addr_ok = addr_hit && (owner == OWN_DATA);
  assign bus.inst_data_ok = data_hit && (owner == OWN_INST);
  assign bus.data_data_ok = data_hit && (owner == OWN_DATA);

  // Read data is broadcast; consumers qualify it with their data_ok.
  assign bus.inst_rdata = bus.mem_rdata;
  assign bus.data_rdata = bus.mem_rdata;

endmodule
